// File: rtl/rtc_pkg.sv
// ============================================================================
//  Module      : rtc_pkg
//  Description : Shared state encoding, phase-timer width and RTC bus
//                polarity constants for the RTC init sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_pkg;

  localparam int   c_phase_tw    = $clog2(16);
  localparam logic c_strobe_act  = 1'b0;
  localparam logic c_strobe_idle = 1'b1;
  localparam logic c_ad_addr     = 1'b0;
  localparam logic c_ad_data     = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RAM_WAIT = 4'd1,
    ST_FETCH    = 4'd2,
    ST_LATCH    = 4'd3,
    ST_ADDR     = 4'd4,
    ST_DATA     = 4'd5,
    ST_RB_ADDR  = 4'd6,
    ST_RB_DATA  = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rtc_bus_phase.sv
// ============================================================================
//  Module      : rtc_bus_phase
//  Description : One timed RTC bus phase: strobes low T_PULSE cycles, then all
//                strobes high T_GAP cycles; runs back-to-back while go is held.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_phase
  import rtc_pkg::*;
#(
  parameter int DW      = 8,
  parameter int T_PULSE = 3,
  parameter int T_GAP   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic          is_read,
  input  logic          a_d_val,
  input  logic [DW-1:0] value,
  input  logic [DW-1:0] ad_in,
  output logic          cs,
  output logic          rd,
  output logic          wr,
  output logic          a_d,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  output logic [DW-1:0] sample,
  output logic          phase_done
);

  logic [c_phase_tw-1:0] r_cnt;
  logic                  r_gap;
  logic [DW-1:0]         r_sample;
  logic                  w_pulse_last;
  logic                  w_gap_last;
  logic                  w_strobe;

  assign w_pulse_last = !r_gap && (r_cnt == c_phase_tw'(T_PULSE - 1));
  assign w_gap_last   = r_gap && (r_cnt == c_phase_tw'(T_GAP - 1));

  // Pulse and gap share one 4-bit timer so T_PULSE+T_GAP may exceed 15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_gap    <= 1'b0;
      r_sample <= '0;
    end else if (!go) begin
      r_cnt <= '0;
      r_gap <= 1'b0;
    end else if (w_pulse_last) begin
      r_cnt <= '0;
      r_gap <= 1'b1;
      if (is_read) r_sample <= ad_in;
    end else if (w_gap_last) begin
      r_cnt <= '0;
      r_gap <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_strobe   = go && !r_gap;
  assign cs         = w_strobe ? c_strobe_act : c_strobe_idle;
  assign wr         = (w_strobe && !is_read) ? c_strobe_act : c_strobe_idle;
  assign rd         = (w_strobe && is_read) ? c_strobe_act : c_strobe_idle;
  assign a_d        = go ? a_d_val : c_ad_addr;
  assign ad_oe      = go && !is_read;
  assign ad_out     = ad_oe ? value : '0;
  assign sample     = r_sample;
  assign phase_done = go && w_gap_last;

endmodule

`default_nettype wire

// File: rtl/rtc_init_seq.sv
// ============================================================================
//  Module      : rtc_init_seq
//  Description : Waits for RAM preload, then writes N_REGS table entries to an
//                RTC over a multiplexed address/data bus. Optional readback
//                verify enabled by macro RTC_INIT_READBACK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_init_seq
  import rtc_pkg::*;
#(
  parameter int N_REGS  = 4,
  parameter int DW      = 8,
  parameter int T_PULSE = 3,
  parameter int T_GAP   = 2,
  localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ram_init_req,
  input  logic             ram_init_done,
  output logic             tbl_rd_en,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [2*DW-1:0]  tbl_data,
  output logic             a_d,
  output logic             cs,
  output logic             rd,
  output logic             wr,
  output logic [DW-1:0]    ad_out,
  output logic             ad_oe,
  input  logic [DW-1:0]    ad_in
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_entry_next;
  state_t           w_after_data;
  state_t           w_last_phase;
  logic [IDX_W-1:0] r_idx;
  logic [DW-1:0]    r_addr;
  logic [DW-1:0]    r_value;
  logic             w_last_entry;
  logic             w_entry_end;
  logic             w_start_acc;
  logic             w_go;
  logic             w_is_read;
  logic             w_a_d_val;
  logic [DW-1:0]    w_value;
  logic [DW-1:0]    w_sample;
  logic             w_phase_done;

  assign w_last_entry = (r_idx == IDX_W'(N_REGS - 1));
  assign w_entry_next = w_last_entry ? ST_DONE : ST_FETCH;
  assign w_start_acc  = (r_state == ST_IDLE) && start;
  assign w_entry_end  = w_phase_done && (r_state == w_last_phase);

`ifdef RTC_INIT_READBACK_EN
  assign w_after_data = ST_RB_ADDR;
  assign w_last_phase = ST_RB_DATA;
`else
  assign w_after_data = w_entry_next;
  assign w_last_phase = ST_DATA;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_value <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_acc || r_state == ST_DONE) r_idx <= '0;
      else if (w_entry_end && !w_last_entry) r_idx <= r_idx + 1'b1;
      if (r_state == ST_LATCH) {r_addr, r_value} <= tbl_data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_RAM_WAIT;
      ST_RAM_WAIT: if (ram_init_done) w_next = ST_FETCH;
      ST_FETCH:    w_next = ST_LATCH;
      ST_LATCH:    w_next = ST_ADDR;
      ST_ADDR:     if (w_phase_done) w_next = ST_DATA;
      ST_DATA:     if (w_phase_done) w_next = w_after_data;
`ifdef RTC_INIT_READBACK_EN
      ST_RB_ADDR:  if (w_phase_done) w_next = ST_RB_DATA;
      ST_RB_DATA:  if (w_phase_done) w_next = w_entry_next;
`endif
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);
  assign ram_init_req = (r_state == ST_RAM_WAIT);
  assign tbl_rd_en    = (r_state == ST_FETCH);
  assign tbl_idx      = r_idx;

  assign w_go      = (r_state == ST_ADDR) || (r_state == ST_DATA) ||
                     (r_state == ST_RB_ADDR) || (r_state == ST_RB_DATA);
  assign w_is_read = (r_state == ST_RB_DATA);
  assign w_a_d_val = (r_state == ST_DATA) || (r_state == ST_RB_DATA);
  assign w_value   = ((r_state == ST_ADDR) || (r_state == ST_RB_ADDR)) ? r_addr : r_value;

  rtc_bus_phase #(
    .DW      (DW),
    .T_PULSE (T_PULSE),
    .T_GAP   (T_GAP)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .go         (w_go),
    .is_read    (w_is_read),
    .a_d_val    (w_a_d_val),
    .value      (w_value),
    .ad_in      (ad_in),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .a_d        (a_d),
    .ad_out     (ad_out),
    .ad_oe      (ad_oe),
    .sample     (w_sample),
    .phase_done (w_phase_done)
  );

`ifdef RTC_INIT_READBACK_EN
  logic r_err;

  // Mismatch is sticky for the whole run; only a new accepted start clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (r_state == ST_RB_DATA && w_phase_done && w_sample != r_value) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_sample;

  assign w_unused_sample = ^w_sample;
  assign err             = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rtc_init_seq.sv
// ============================================================================
//  Module      : tb_rtc_init_seq
//  Description : Directed self-checking bench for rtc_init_seq.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rtc_init_seq;

  localparam int N_REGS  = 4;
  localparam int DW      = 8;
  localparam int T_PULSE = 3;
  localparam int T_GAP   = 2;
`ifdef RTC_INIT_READBACK_EN
  localparam int PH_PER_ENTRY = 3;
  localparam int EXP_DONE     = 90;
  localparam int EXP_RD       = 4;
  localparam int MID_CYC      = 32;
  localparam logic EXP_ERR    = 1'b1;
`else
  localparam int PH_PER_ENTRY = 2;
  localparam int EXP_DONE     = 50;
  localparam int EXP_RD       = 0;
  localparam int MID_CYC      = 22;
  localparam logic EXP_ERR    = 1'b0;
`endif
  localparam int EXP_WR = N_REGS * PH_PER_ENTRY;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic            ram_init_done = 1'b0;
  logic [2*DW-1:0] tbl_data = '0;
  logic [DW-1:0]   ad_in;
  logic            busy, done, err, ram_init_req, tbl_rd_en;
  logic [1:0]      tbl_idx;
  logic            a_d, cs, rd, wr, ad_oe;
  logic [DW-1:0]   ad_out;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rtc_init_seq #(
    .N_REGS (N_REGS), .DW (DW), .T_PULSE (T_PULSE), .T_GAP (T_GAP)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .busy (busy), .done (done),
    .err (err), .ram_init_req (ram_init_req), .ram_init_done (ram_init_done),
    .tbl_rd_en (tbl_rd_en), .tbl_idx (tbl_idx), .tbl_data (tbl_data),
    .a_d (a_d), .cs (cs), .rd (rd), .wr (wr), .ad_out (ad_out),
    .ad_oe (ad_oe), .ad_in (ad_in)
  );

  logic [7:0] tbl_addr [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
  logic [7:0] tbl_val  [4] = '{8'h20, 8'h06, 8'h15, 8'h03};
  logic [7:0] rtc_mem  [256];
  logic [7:0] rtc_addr = 8'h00;

  // Table ROM and RTC chip model; register 0x0B reads back corrupted.
  always @(negedge clk) begin
    if (tbl_rd_en) tbl_data = {tbl_addr[tbl_idx], tbl_val[tbl_idx]};
    if (!cs && !wr && !a_d) rtc_addr = ad_out;
    if (!cs && !wr && a_d) rtc_mem[rtc_addr] = ad_out;
  end
  always @* ad_in = (rtc_addr == 8'h0B) ? 8'h07 : rtc_mem[rtc_addr];

  function automatic logic [7:0] exp_ad(input int k);
    int e = k / PH_PER_ENTRY;
    int p = k % PH_PER_ENTRY;
    return (p == 1) ? tbl_val[e] : tbl_addr[e];
  endfunction

  int m_done_cyc, m_done_cnt, m_wr_pulses, m_rd_pulses, m_bad_len, m_run;
  int m_cs_bad, m_both_low, m_rd_en_cnt, m_busy_low;
  logic m_busy_after, m_err_at_done;
  logic [7:0] m_ad [32];
  logic       m_a_d [32];
  logic [1:0] m_idx [8];

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic collect(input int max_cyc, input bit stop_at_done, input int inj_a, input int inj_b);
    logic prev_wr = 1'b1;
    logic prev_rd = 1'b1;
    m_done_cyc = 0; m_done_cnt = 0; m_wr_pulses = 0; m_rd_pulses = 0; m_bad_len = 0;
    m_run = 0; m_cs_bad = 0; m_both_low = 0; m_rd_en_cnt = 0; m_busy_low = 0;
    m_busy_after = 1'b1; m_err_at_done = 1'bx;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c > 1) @(negedge clk);
      start = (c == inj_a) || (c == inj_b);
      if (cs !== (wr & rd)) m_cs_bad++;
      if (!rd && !wr) m_both_low++;
      if (!rd && prev_rd) m_rd_pulses++;
      if (!wr) begin
        if (prev_wr) begin
          if (m_wr_pulses < 32) begin
            m_ad[m_wr_pulses]  = ad_out;
            m_a_d[m_wr_pulses] = a_d;
          end
          m_wr_pulses++;
        end
        m_run++;
      end else begin
        if (!prev_wr && m_run != T_PULSE) m_bad_len++;
        m_run = 0;
      end
      prev_wr = wr;
      prev_rd = rd;
      if (tbl_rd_en) begin
        if (m_rd_en_cnt < 8) m_idx[m_rd_en_cnt] = tbl_idx;
        m_rd_en_cnt++;
      end
      if (done) begin
        m_done_cnt++;
        if (m_done_cyc == 0) begin
          m_done_cyc = c;
          m_err_at_done = err;
        end
      end else if (!busy && m_done_cyc == 0) begin
        m_busy_low++;
      end
      if (stop_at_done && m_done_cyc != 0 && c > m_done_cyc) begin
        m_busy_after = busy;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int busy_cnt = 0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, ram_init_req, tbl_rd_en, ad_oe} !== 6'b0)
      $display("FAIL reset_status: got %b required 000000", {busy, done, err, ram_init_req, tbl_rd_en, ad_oe});
    else passed++;
    checks++;
    if ({cs, rd, wr, a_d, ad_out, tbl_idx} !== {4'b1110, 8'h00, 2'b00})
      $display("FAIL reset_bus: got %h required %h", {cs, rd, wr, a_d, ad_out, tbl_idx}, {4'b1110, 8'h00, 2'b00});
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ram_init_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy || ram_init_req || tbl_rd_en || !cs) busy_cnt++;
    end
    checks++;
    if (busy_cnt !== 0) $display("FAIL reset_no_autostart: active cycles %0d required 0", busy_cnt);
    else passed++;
  endtask

  task automatic test_write_sequence();
    ram_init_done = 1'b1;
    pulse_start();
    collect(200, 1'b1, 0, 0);
    checks++;
    if (m_done_cyc !== EXP_DONE) $display("FAIL seq_done_cycle: got %0d required %0d", m_done_cyc, EXP_DONE);
    else passed++;
    checks++;
    if (m_wr_pulses !== EXP_WR) $display("FAIL seq_wr_pulses: got %0d required %0d", m_wr_pulses, EXP_WR);
    else passed++;
    checks++;
    if (m_bad_len !== 0) $display("FAIL seq_wr_len: bad pulses %0d required 0", m_bad_len);
    else passed++;
    checks++;
    if (m_rd_pulses !== EXP_RD) $display("FAIL seq_rd_pulses: got %0d required %0d", m_rd_pulses, EXP_RD);
    else passed++;
    for (int k = 0; k < EXP_WR; k++) begin
      checks++;
      if (m_ad[k] !== exp_ad(k)) $display("FAIL seq_ad_out[%0d]: got %h required %h", k, m_ad[k], exp_ad(k));
      else passed++;
      checks++;
      if (m_a_d[k] !== ((k % PH_PER_ENTRY) == 1)) $display("FAIL seq_a_d[%0d]: got %b required %b", k, m_a_d[k], (k % PH_PER_ENTRY) == 1);
      else passed++;
    end
    checks++;
    if (m_cs_bad !== 0 || m_both_low !== 0) $display("FAIL seq_strobes: cs_bad %0d both_low %0d required 0 0", m_cs_bad, m_both_low);
    else passed++;
    checks++;
    if (m_rd_en_cnt !== N_REGS) $display("FAIL seq_tbl_reads: got %0d required %0d", m_rd_en_cnt, N_REGS);
    else passed++;
    for (int e = 0; e < N_REGS; e++) begin
      checks++;
      if (m_idx[e] !== 2'(e)) $display("FAIL seq_tbl_idx[%0d]: got %0d required %0d", e, m_idx[e], e);
      else passed++;
    end
    checks++;
    if (m_busy_low !== 0 || m_busy_after !== 1'b0) $display("FAIL seq_busy: low_while_run %0d after_done %b required 0 0", m_busy_low, m_busy_after);
    else passed++;
    checks++;
    if (m_err_at_done !== EXP_ERR) $display("FAIL seq_err: got %b required %b", m_err_at_done, EXP_ERR);
    else passed++;
  endtask

  task automatic test_ram_wait();
    int req_hi = 0;
    int rd_en_cnt = 0;
    int bus_cnt = 0;
    ram_init_done = 1'b0;
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      if (ram_init_req) req_hi++;
      if (tbl_rd_en) rd_en_cnt++;
      if (!cs || !wr || !rd || ad_oe) bus_cnt++;
      @(negedge clk);
    end
    checks++;
    if (req_hi !== 20) $display("FAIL ramwait_req: high cycles %0d required 20", req_hi);
    else passed++;
    checks++;
    if (rd_en_cnt !== 0 || bus_cnt !== 0) $display("FAIL ramwait_quiet: rd_en %0d bus %0d required 0 0", rd_en_cnt, bus_cnt);
    else passed++;
    ram_init_done = 1'b1;
    collect(200, 1'b1, 0, 0);
    checks++;
    if (m_done_cyc !== EXP_DONE || ram_init_req !== 1'b0)
      $display("FAIL ramwait_resume: done cycle %0d req %b required %0d 0", m_done_cyc, ram_init_req, EXP_DONE);
    else passed++;
  endtask

  task automatic test_start_ignored();
    ram_init_done = 1'b1;
    pulse_start();
    collect(120, 1'b0, 10, 30);
    checks++;
    if (m_done_cnt !== 1 || m_done_cyc !== EXP_DONE)
      $display("FAIL busy_start: done pulses %0d at %0d required 1 at %0d", m_done_cnt, m_done_cyc, EXP_DONE);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle: busy %b required 0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid();
    ram_init_done = 1'b1;
    pulse_start();
    repeat (MID_CYC - 1) @(negedge clk);
    checks++;
    if ({wr, a_d, tbl_idx} !== 4'b0101) $display("FAIL midrst_pre: wr,a_d,idx %b required 0101", {wr, a_d, tbl_idx});
    else passed++;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cs, wr, rd, ad_oe, busy, a_d} !== 6'b111000)
      $display("FAIL midrst_bus: cs,wr,rd,oe,busy,a_d %b required 111000", {cs, wr, rd, ad_oe, busy, a_d});
    else passed++;
    checks++;
    if ({tbl_idx, done, err, ram_init_req, tbl_rd_en, ad_out} !== 14'h0)
      $display("FAIL midrst_state: got %h required 0", {tbl_idx, done, err, ram_init_req, tbl_rd_en, ad_out});
    else passed++;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    pulse_start();
    collect(200, 1'b1, 0, 0);
    checks++;
    if (m_idx[0] !== 2'd0 || m_ad[0] !== 8'h0A || m_done_cyc !== EXP_DONE)
      $display("FAIL midrst_rerun: idx %0d ad %h done %0d required 0 0a %0d", m_idx[0], m_ad[0], m_done_cyc, EXP_DONE);
    else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_sequence();
    test_ram_wait();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
